// File: rtl/nibble_ctrl_pkg.sv
// Shared definitions for the nibble run controller.
//   run_state_t            : controller state encoding (PAUSED, RUN)
//   DEFAULT_DEBOUNCE_LIMIT : default cycles a switch must be stable
//   DEFAULT_TICK_LIMIT     : default cycles per auto-count step
//   cnt_width()            : width of a counter covering 0..limit-1
package nibble_ctrl_pkg;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } run_state_t;

  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int DEFAULT_TICK_LIMIT     = 25000000;

  // Limits of 1 or 2 still need a one-bit counter.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Debounces one raw switch and emits a one-cycle press pulse.
//   i_Clk    : clock, rising edge
//   i_Reset  : synchronous, active-high reset
//   i_Switch : raw switch level
//   o_Press  : one-cycle pulse, the cycle after the debounced level rises
// The debounced level only follows the raw input after DEBOUNCE_LIMIT
// consecutive cycles of disagreement; any agreeing cycle restarts the count.
module switch_debounce
  import nibble_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Press
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [CNT_W-1:0] count;
  logic             level;
  logic             level_q;
  logic             press;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count   <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so level_q really is the previous level.
      if (i_Switch != level) begin
        if (count == CNT_MAX) begin
          level <= i_Switch;
          count <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        count <= '0;
      end
      level_q <= level;
      // Registered edge detect: the pulse lands one cycle after the rise.
      press   <= level & ~level_q;
    end
  end

  assign o_Press = press;

endmodule

// File: rtl/nibble_run_ctrl.sv
// Four-button nibble counter controller.
//   i_Clk      : clock, rising edge
//   i_Reset    : synchronous, active-high reset
//   i_Switch_1 : raw start/pause button
//   i_Switch_2 : raw direction-toggle button
//   i_Switch_3 : raw single-step button (PAUSED only)
//   i_Switch_4 : raw clear button
//   o_Nibble   : current 4-bit count
//   o_Running  : high while in RUN
//   o_Down     : count direction, 1 = down
//   o_Wrap     : one-cycle pulse on the cycle the count shows its wrapped value
// In RUN the count advances once every TICK_LIMIT cycles; in PAUSED a step
// press advances it once. Clear wins over any same-cycle advance.
module nibble_run_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int TICK_LIMIT     = DEFAULT_TICK_LIMIT
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Nibble,
  output logic       o_Running,
  output logic       o_Down,
  output logic       o_Wrap
);

  localparam int                TICK_W   = cnt_width(TICK_LIMIT);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_LIMIT - 1);

  logic start_press;
  logic dir_press;
  logic step_press;
  logic clear_press;

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_start (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_1),
    .o_Press  (start_press)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_dir (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_2),
    .o_Press  (dir_press)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_step (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_3),
    .o_Press  (step_press)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_clear (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_4),
    .o_Press  (clear_press)
  );

  run_state_t        state;
  run_state_t        state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              advance;
  logic [3:0]        nibble;
  logic              down;
  logic              wrap;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt = state;
    tick      = 1'b0;
    advance   = 1'b0;

    if (start_press) begin
      state_nxt = (state == RUN) ? PAUSED : RUN;
    end

    // A tick in the same cycle as a pause press is still applied, because
    // both decisions look at the current state, not state_nxt.
    tick    = (state == RUN) && (tick_cnt == TICK_MAX);
    advance = tick || (step_press && (state == PAUSED));
  end

  // Tick counter restarts on every state change and on clear, and sits at 0
  // while paused.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tick_cnt <= '0;
    end else if (clear_press || start_press || (state != RUN) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Count register. The advance uses the direction held before this edge,
  // so a same-cycle direction press only affects later steps.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      nibble <= 4'd0;
      down   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear_press) begin
        nibble <= 4'd0;
      end else if (advance) begin
        if (down) begin
          nibble <= nibble - 4'd1;
          wrap   <= (nibble == 4'd0);
        end else begin
          nibble <= nibble + 4'd1;
          wrap   <= (nibble == 4'hF);
        end
      end
      if (dir_press) begin
        down <= ~down;
      end
    end
  end

  assign o_Nibble  = nibble;
  assign o_Running = (state == RUN);
  assign o_Down    = down;
  assign o_Wrap    = wrap;

endmodule

// File: tb/tb_nibble_run_ctrl.sv
// Self-checking bench for nibble_run_ctrl with DEBOUNCE_LIMIT=4, TICK_LIMIT=8.
// A behavioural model predicts every output change (value and cycle) into a
// scoreboard queue; a monitor pops an entry whenever the DUT outputs change.
module tb_nibble_run_ctrl;

  localparam int DL = 4;
  localparam int TL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0;
  logic [3:0] o_Nibble;
  logic       o_Running;
  logic       o_Down;
  logic       o_Wrap;

  always #5 clk = ~clk;

  nibble_run_ctrl #(.DEBOUNCE_LIMIT(DL), .TICK_LIMIT(TL)) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .o_Nibble   (o_Nibble),
    .o_Running  (o_Running),
    .o_Down     (o_Down),
    .o_Wrap     (o_Wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [6:0] outs;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within its cycle budget", name);
  endtask

  // ---------------- behavioural model ----------------
  // Switch i: level follows raw after DL consecutive disagreeing cycles; a
  // rise takes effect on the outputs two edges later. Ticks fall every TL
  // cycles measured from the last restart (state change, clear, reset).
  logic       m_lvl [4];
  int         m_run [4];
  int         m_due [4];
  bit         m_running = 1'b0;
  bit         m_down    = 1'b0;
  bit         m_wrap    = 1'b0;
  logic [3:0] m_nib     = 4'd0;
  int         m_restart = 0;
  int         m_wraps   = 0;
  logic [6:0] m_prev    = 7'd0;

  function automatic logic [6:0] m_outs();
    return {m_nib, m_running, m_down, m_wrap};
  endfunction

  task automatic model_edge(input logic [3:0] s, input logic r);
    bit act [4];
    bit tick;
    bit adv;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
        m_due[i] = -1;
      end
      m_running = 1'b0;
      m_down    = 1'b0;
      m_wrap    = 1'b0;
      m_nib     = 4'd0;
      m_restart = cyc + 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        act[i] = (m_due[i] == cyc);
        if (act[i]) m_due[i] = -1;
      end
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DL) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i]) m_due[i] = cyc + 2;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      tick = m_running && (((cyc - m_restart) % TL) == TL - 1);
      adv  = tick || (act[2] && !m_running);
      if (act[3]) begin
        m_nib  = 4'd0;
        m_wrap = 1'b0;
      end else if (adv) begin
        m_wrap = m_down ? (m_nib == 4'd0) : (m_nib == 4'd15);
        m_nib  = m_down ? m_nib - 4'd1 : m_nib + 4'd1;
      end else begin
        m_wrap = 1'b0;
      end
      if (act[1]) m_down = !m_down;
      if (act[0]) m_running = !m_running;
      if (act[0] || act[3]) m_restart = cyc + 1;
    end
    if (m_wrap) m_wraps++;
    if (m_outs() != m_prev) begin
      sb_q.push_back('{cyc + 1, m_outs()});
      m_prev = m_outs();
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, predict the coming edge, wait.
  task automatic step(input logic [3:0] s, input logic r);
    sw  = s;
    rst = r;
    model_edge(s, r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic press(input int idx);
    for (int k = 0; k < 6; k++) step(4'(1 << idx), 1'b0);
    for (int k = 0; k < 6; k++) step(4'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [6:0] mon_last  = 7'd0;
  int         dut_wraps = 0;

  always @(negedge clk) begin
    logic [6:0] cur;
    exp_t       e;
    if (cyc >= 3) begin
      cur = {o_Nibble, o_Running, o_Down, o_Wrap};
      if (o_Wrap) dut_wraps++;
      if (cur !== mon_last) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: outputs changed to %0h with nothing expected (cycle %0d)", cur, cyc);
        end else begin
          e = sb_q.pop_front();
          check("evt_cycle", cyc, e.cyc);
          check("evt_outputs", {25'd0, cur}, {25'd0, e.outs});
        end
        mon_last = cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit         found;
    logic [3:0] s;
    logic       r;

    repeat (3) step(4'b0, 1'b1);
    check("reset_nibble",  o_Nibble,  0);
    check("reset_running", o_Running, 0);
    check("reset_down",    o_Down,    0);
    check("reset_wrap",    o_Wrap,    0);

    // Bouncing step button, then a clean hold: one step only.
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    repeat (4) step(4'b0100, 1'b0);
    repeat (8) step(4'b0000, 1'b0);
    check("bounce_step", o_Nibble, 1);

    // Run up through a wrap.
    press(0);
    check("run_on", o_Running, 1);
    repeat (8 * 16) step(4'b0, 1'b0);
    check("run_still_on", o_Running, 1);

    // Pause, clear, then down-wrap with a single step.
    press(0);
    check("paused", o_Running, 0);
    press(3);
    check("cleared", o_Nibble, 0);
    press(1);
    check("down_set", o_Down, 1);
    press(2);
    check("down_wrap_nib", o_Nibble, 15);

    // Clear landing on the tick that would move 7 -> 8.
    press(1);
    press(3);
    press(0);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_running && m_nib == 4'd7 && (((cyc + 5 - m_restart) % TL) == TL - 1))
        found = 1'b1;
      else
        step(4'b0, 1'b0);
    end
    if (!found) timeout("collision_align");
    repeat (6) step(4'b1000, 1'b0);
    check("coll_nibble",  o_Nibble,  0);
    check("coll_running", o_Running, 1);
    check("coll_wrap",    o_Wrap,    0);
    repeat (6) step(4'b0, 1'b0);

    // Step presses while running are ignored (scoreboard sees only ticks).
    press(2);
    press(2);

    // Reset mid-run at nibble 9 counting down.
    press(1);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_running && m_down && m_nib == 4'd9) found = 1'b1;
      else step(4'b0, 1'b0);
    end
    if (!found) timeout("reset_align");
    step(4'b0, 1'b1);
    check("rst_nibble",  o_Nibble,  0);
    check("rst_running", o_Running, 0);
    check("rst_down",    o_Down,    0);
    check("rst_wrap",    o_Wrap,    0);

    // Start button held through reset: press counts only after release of reset.
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    check("held_in_reset", o_Running, 0);
    repeat (8) step(4'b0001, 1'b0);
    repeat (8) step(4'b0000, 1'b0);
    check("held_start", o_Running, 1);

    // Random switch activity with occasional reset.
    s = 4'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) s[i] = ~s[i];
      r = ($urandom_range(0, 599) == 0);
      step(s, r);
    end
    repeat (20) step(4'b0, 1'b0);

    #1;
    check("sb_drained", sb_q.size(), 0);
    check("wrap_count", dut_wraps, m_wraps);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
